// File: rtl/day_of_yr_decode.sv
// Converts a 1-based day-of-year into month / day-of-month for a Gregorian or
// Symmetry454 calendar, by subtracting one month length per clock cycle.
`timescale 1ns/1ps

module day_of_yr_decode #(
  parameter logic cal_select = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  dayOfYear,
  input  logic [10:0] year,
  output logic [3:0]  month,
  output logic [5:0]  dayOfMonth,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t     state;
  logic [8:0] rem;
  logic       leap_q;
  logic [3:0] cnt;

  logic       leap_in;
  logic [8:0] year_len;
  logic [8:0] cur_len;
  logic       in_range;
  logic       unused_year;

  function automatic logic [8:0] month_len(input logic [3:0] m, input logic leap);
    logic [8:0] len;
    len = 9'd31;
    if (cal_select) begin
      // 4-5-4 weeks per quarter: the middle month of each quarter is 35 days.
      case (m)
        4'd2, 4'd5, 4'd8, 4'd11: len = 9'd35;
        default:                 len = 9'd28;
      endcase
    end else begin
      case (m)
        4'd2:                    len = leap ? 9'd29 : 9'd28;
        4'd4, 4'd6, 4'd9, 4'd11: len = 9'd30;
        default:                 len = 9'd31;
      endcase
    end
    return len;
  endfunction

  assign unused_year = ^year[10:2];

  always_comb begin
    leap_in  = !cal_select && (year[1:0] == 2'b00);
    year_len = cal_select ? 9'd364 : (leap_in ? 9'd366 : 9'd365);
    in_range = (dayOfYear != 9'd0) && (dayOfYear <= year_len);
    cur_len  = month_len(cnt, leap_q);
  end

  assign busy = (state == CALC);

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rem        <= '0;
      leap_q     <= 1'b0;
      cnt        <= '0;
      month      <= '0;
      dayOfMonth <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (in_range) begin
              rem    <= dayOfYear;
              leap_q <= leap_in;
              cnt    <= 4'd1;
              state  <= CALC;
            end else begin
              month      <= '0;
              dayOfMonth <= '0;
              err        <= 1'b1;
              done       <= 1'b1;
            end
          end
        end
        CALC: begin
          // The range check at capture guarantees the remainder fits in
          // December, so cnt stops at 12 and rem never underflows.
          if (rem > cur_len) begin
            rem <= rem - cur_len;
            cnt <= cnt + 4'd1;
          end else begin
            month      <= cnt;
            dayOfMonth <= rem[5:0];
            err        <= 1'b0;
            done       <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/day_of_yr_decode.md
DAY_OF_YR_DECODE -- requirements
Module: day_of_yr_decode

Interface
REQ-001 SHALL have parameter cal_select, default 1'b0; calendar type: 1'b0 Gregorian, 1'b1 Symmetry454.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to decode; sampled only in IDLE.
REQ-005 SHALL have port dayOfYear, input, 9 bits: day of year, 1-based.
REQ-006 SHALL have port year, input, 11 bits: calendar year.
REQ-007 SHALL have port month, output, 4 bits: decoded month, 1..12.
REQ-008 SHALL have port dayOfMonth, output, 6 bits: decoded day of month, 1-based.
REQ-009 SHALL have port busy, output, 1 bit: high while in CALC.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when month/dayOfMonth/err are updated.
REQ-011 SHALL have port err, output, 1 bit: last request was out of range.

Function
REQ-012 SHALL treat a year as a leap year when year[1:0]==2'b00 and cal_select==0; Symmetry454 years are never leap.
REQ-013 SHALL use Gregorian month lengths 31,28/29,31,30,31,30,31,31,30,31,30,31, with February 29 in a leap year.
REQ-014 SHALL use Symmetry454 month lengths 28,35,28 repeated for four quarters, giving a 364-day year.
REQ-015 SHALL compute year length as 365 or 366 (Gregorian, non-leap or leap) and 364 (Symmetry454).
REQ-016 SHALL implement an FSM with states IDLE and CALC; the reset state is IDLE.
REQ-017 IDLE, start==1, and dayOfYear in 1..yearLen: on that edge SHALL register dayOfYear into an internal 9-bit remainder, register the year's leap status, set the month counter to 1, and go to CALC.
REQ-018 IDLE, start==1, and dayOfYear==0 or dayOfYear>yearLen: on that edge SHALL set err=1, month=0, dayOfMonth=0 and done=1, and stay in IDLE (latency 1).
REQ-019 Each CALC edge: if remainder > len(current month), SHALL subtract len from the remainder and increment the month counter.
REQ-020 Each CALC edge: otherwise SHALL set month to the counter, dayOfMonth to remainder[5:0], err=0, done=1, and go to IDLE.
REQ-021 Latency from the capture edge to the done edge SHALL equal the decoded month number (1..12 cycles).
REQ-022 SHALL ignore start while in CALC; inputs captured at start remain in use and later input changes have no effect.
REQ-023 done SHALL be high for exactly one cycle per accepted request; start held high in IDLE after done SHALL begin a new request on the next edge.
REQ-024 month, dayOfMonth and err SHALL hold their values between done pulses.
REQ-025 busy SHALL equal (state==CALC).
REQ-026 The month counter SHALL never exceed 12; remainder arithmetic SHALL be 9-bit unsigned with no underflow, guaranteed by the range check in REQ-017.

Reset
REQ-027 reset==1 at an edge SHALL force state IDLE, month=0, dayOfMonth=0, busy=0, done=0, err=0, regardless of start.
REQ-028 reset asserted mid-CALC SHALL abort the request with no done pulse; reset SHALL have priority over every other event.

Verification
REQ-029 cal_select=0, year=2019, dayOfYear=60, start pulse -> done 3 cycles after capture, month=3, dayOfMonth=1, err=0.
REQ-030 cal_select=0, year=2020, dayOfYear=60 -> month=2, dayOfMonth=29, latency 2; dayOfYear=366 -> month=12, dayOfMonth=31, latency 12.
REQ-031 cal_select=0, year=2019, dayOfYear=366, and separately dayOfYear=0 -> done after 1 cycle, err=1, month=0, dayOfMonth=0.
REQ-032 cal_select=1, any year: dayOfYear=63 -> month=2, dayOfMonth=35; dayOfYear=364 -> month=12, dayOfMonth=28; dayOfYear=365 -> err=1.
REQ-033 Gregorian, year=2019, dayOfYear=300, start pulsed again plus dayOfYear changed to 5 during CALC -> single done, month=10, dayOfMonth=27.
REQ-034 Request dayOfYear=300 with reset pulsed 4 cycles after capture -> busy=0, done never pulses, all outputs 0; next request dayOfYear=1 -> month=1, dayOfMonth=1, latency 1.
